// File: rtl/alu_issue.sv
// RISC-V R/I-type ALU decode/issue stage with a registered output and a one-entry skid buffer.
// An accepted instruction appears on out_* the next cycle; when out_ready is low, in_ready drops once the skid entry is full.
module alu_issue #(
  parameter int XLEN     = 32,
  parameter bit ILL_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [3:0]      alu_op,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  localparam logic [3:0] ADD_OP      = 4'd0;
  localparam logic [3:0] SUB_OP      = 4'd1;
  localparam logic [3:0] LEFT_L_OP   = 4'd2;
  localparam logic [3:0] LESS_OP     = 4'd3;
  localparam logic [3:0] XOR_OP      = 4'd4;
  localparam logic [3:0] RIGHT_L_OP  = 4'd5;
  localparam logic [3:0] RIGHT_AR_OP = 4'd6;
  localparam logic [3:0] OR_OP       = 4'd7;
  localparam logic [3:0] AND_OP      = 4'd8;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu_op;
    logic [4:0]      rd;
    logic            illegal;
  } pay_t;

  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b10} state_t;

  state_t     state, state_nxt;
  pay_t       dec, out_q, skid_q;
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       is_r, is_i, is_shift_i, ill, accept, push;
  logic       unused_rs;

  assign opcode     = instr[6:0];
  assign f3         = instr[14:12];
  assign f7         = instr[31:25];
  assign is_r       = (opcode == OPC_R);
  assign is_i       = (opcode == OPC_I);
  assign is_shift_i = is_i && (f3 == 3'b001 || f3 == 3'b101);
  // rs1 index is consumed by the register file upstream; only its data arrives here
  assign unused_rs  = ^instr[19:15];

  always_comb begin
    ill = !(is_r || is_i) || (f3 == 3'b011);
    if (is_r && !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))))
      ill = 1'b1;
    if (is_i && f3 == 3'b001 && f7 != F7_BASE)
      ill = 1'b1;
    if (is_i && f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
      ill = 1'b1;
  end

  always_comb begin
    dec        = '0;
    dec.op1    = rs1_data;
    dec.rd     = instr[11:7];
    dec.alu_op = ADD_OP;
    case (f3)
      3'b000:  dec.alu_op = (is_r && f7 == F7_ALT) ? SUB_OP : ADD_OP;
      3'b001:  dec.alu_op = LEFT_L_OP;
      3'b010:  dec.alu_op = LESS_OP;
      3'b100:  dec.alu_op = XOR_OP;
      3'b101:  dec.alu_op = (f7 == F7_ALT) ? RIGHT_AR_OP : RIGHT_L_OP;
      3'b110:  dec.alu_op = OR_OP;
      3'b111:  dec.alu_op = AND_OP;
      default: dec.alu_op = ADD_OP;
    endcase
    if (is_r)
      dec.op2 = rs2_data;
    else if (is_shift_i)
      dec.op2 = {{(XLEN-5){1'b0}}, instr[24:20]};
    else
      dec.op2 = {{(XLEN-12){instr[31]}}, instr[31:20]};
    dec.illegal = ill;
    if (ill) begin
      dec.alu_op = ADD_OP;
      dec.op2    = '0;
    end
  end

  assign accept = in_valid && in_ready;
  // with trapping disabled, illegal encodings are consumed without occupying a slot
  assign push   = accept && (ILL_TRAP || !dec.illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !out_ready)      state_nxt = TWO;
        else if (!push && out_ready) state_nxt = EMPTY;
      end
      TWO:     if (out_ready) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
  end

  // reset payload of all zeros encodes ADD_OP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (state == TWO) begin
        if (out_ready) out_q <= skid_q;
      end else if (push && (state == EMPTY || out_ready)) begin
        out_q <= dec;
      end
      if (state == ONE && push && !out_ready)
        skid_q <= dec;
    end
  end

  assign op1         = out_q.op1;
  assign op2         = out_q.op2;
  assign alu_op      = out_q.alu_op;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.illegal;

endmodule
